// File: rtl/operand_sequencer_pkg.sv
// ============================================================================
// Module  : ebmc_operand_pkg
// Purpose : Shared operand-set type and collector word index for the
//           x/y/z/h operand sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ebmc_operand_pkg;

    localparam int OPW = 32;

    typedef struct packed {
        logic [OPW-1:0] x;
        logic [OPW-1:0] y;
        logic [OPW-1:0] z;
        logic [OPW-1:0] h;
    } operand_set_t;

    typedef enum logic [1:0] {
        IDX_X = 2'd0,
        IDX_Y = 2'd1,
        IDX_Z = 2'd2,
        IDX_H = 2'd3
    } word_idx_e;

endpackage

`default_nettype wire

// File: rtl/operand_sequencer_fifo.sv
// ============================================================================
// Module  : operand_fifo
// Purpose : Synchronous FIFO of complete operand sets with occupancy count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fifo
    import ebmc_operand_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  operand_set_t                 push_data,
    input  logic                         pop,
    output operand_set_t                 head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    operand_set_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_count == c_full_count);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/operand_sequencer.sv
// ============================================================================
// Module  : operand_sequencer
// Purpose : Groups a serial word stream into x/y/z/h operand sets, drops
//           malformed frames and buffers complete sets for the datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_sequencer
    import ebmc_operand_pkg::*;
#(
    parameter int WIDTH = OPW,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             x,
    output logic [WIDTH-1:0]             y,
    output logic [WIDTH-1:0]             z,
    output logic [WIDTH-1:0]             h,
    output logic [$clog2(DEPTH+1)-1:0]   set_count,
    output logic                         err_frame
);

    word_idx_e        r_idx;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;
    logic             r_err;

    logic             w_accept;
    logic             w_is_h;
    logic             w_push;
    logic             w_bad;
    logic             w_full;
    logic             w_empty;
    operand_set_t     w_push_set;
    operand_set_t     w_head;

    assign w_accept   = in_valid && in_ready;
    assign w_is_h     = (r_idx == IDX_H);
    assign w_push     = w_accept && w_is_h && in_last;
    // A frame is malformed whenever in_last disagrees with the word position.
    assign w_bad      = w_accept && (in_last != w_is_h);
    assign w_push_set = '{x: r_x, y: r_y, z: r_z, h: in_data};

    // in_ready deliberately ignores out_ready so a same-cycle pop cannot
    // create a combinational path from the consumer back to the producer.
    assign in_ready   = !reset && (!w_is_h || !w_full);
    assign out_valid  = !w_empty;
    assign err_frame  = r_err;

    assign x = out_valid ? w_head.x : '0;
    assign y = out_valid ? w_head.y : '0;
    assign z = out_valid ? w_head.z : '0;
    assign h = out_valid ? w_head.h : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= IDX_X;
            r_x   <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_bad;
            if (w_accept) begin
                case (r_idx)
                    IDX_X: begin
                        r_x   <= in_data;
                        r_idx <= in_last ? IDX_X : IDX_Y;
                    end
                    IDX_Y: begin
                        r_y   <= in_data;
                        r_idx <= in_last ? IDX_X : IDX_Z;
                    end
                    IDX_Z: begin
                        r_z   <= in_data;
                        r_idx <= in_last ? IDX_X : IDX_H;
                    end
                    default: begin
                        r_idx <= IDX_X;
                    end
                endcase
            end
        end
    end

    operand_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_set),
        .pop       (out_ready),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (set_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_operand_sequencer.sv
// ============================================================================
// Module  : tb_operand_sequencer
// Purpose : Self-checking bench for operand_sequencer against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_sequencer;

    localparam int W  = 32;
    localparam int D  = 2;
    localparam int CW = $clog2(D+1);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [W-1:0]  z;
    logic [W-1:0]  h;
    logic [CW-1:0] set_count;
    logic          err_frame;

    int n_total = 0;
    int n_pass  = 0;

    logic [4*W-1:0] m_sets[$];
    logic [W-1:0]   m_stage[$];
    bit             m_err;
    bit             last_acc;

    operand_sequencer #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y),
        .z         (z),
        .h         (h),
        .set_count (set_count),
        .err_frame (err_frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive one cycle of inputs, compare DUT against the model, then advance
    // the model to what the coming posedge must produce.
    task automatic cycle(input bit v, input logic [W-1:0] d, input bit l, input bit r);
        bit             exp_rdy;
        bit             exp_ov;
        bit             acc;
        bit             pop;
        logic [4*W-1:0] head;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        if (reset) begin
            m_sets.delete();
            m_stage.delete();
            m_err = 1'b0;
        end
        #1;
        exp_ov  = (m_sets.size() != 0);
        head    = exp_ov ? m_sets[0] : '0;
        exp_rdy = !reset && (m_stage.size() < 3 || m_sets.size() < D);
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, exp_ov);
        chk("xyzh", {x, y, z, h}, head);
        chk("set_count", set_count, m_sets.size());
        chk("err_frame", err_frame, m_err);
        acc = 1'b0;
        if (!reset) begin
            acc   = v && exp_rdy;
            pop   = exp_ov && r;
            m_err = 1'b0;
            if (pop) void'(m_sets.pop_front());
            if (acc) begin
                if (m_stage.size() < 3) begin
                    if (l) begin
                        m_err = 1'b1;
                        m_stage.delete();
                    end else begin
                        m_stage.push_back(d);
                    end
                end else begin
                    if (l) m_sets.push_back({m_stage[0], m_stage[1], m_stage[2], d});
                    else   m_err = 1'b1;
                    m_stage.delete();
                end
            end
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [W-1:0] d, input bit l, input bit r);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle(1'b1, d, l, r);
            done = last_acc;
        end
        if (!done) begin
            n_total++;
            $display("FAIL send_timeout: word %0h not accepted within 20 cycles", d);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] base, input bit r);
        for (int i = 0; i < 4; i++) send_word(base + W'(i), (i == 3), r);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        m_err     = 1'b0;
        last_acc  = 1'b0;
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Basic frame with consumer ready
        send_frame(32'd1, 1'b1);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_xyzh", {x, y, z, h}, {32'd1, 32'd2, 32'd3, 32'd4});
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("t1_count_after_pop", set_count, 0);

        // Back-pressure: two sets buffered, third h word stalls
        for (int i = 0; i < 11; i++) send_word(32'd100 + 32'(i), (i % 4 == 3), 1'b0);
        cycle(1'b1, 32'd111, 1'b1, 1'b0);
        chk("t2_stall_ready", in_ready, 0);
        chk("t2_count_full", set_count, 2);
        chk("t2_head_a", {x, h}, {32'd100, 32'd103});
        send_word(32'd111, 1'b1, 1'b1);
        chk("t2_head_i", {x, y, z, h}, {32'd108, 32'd109, 32'd110, 32'd111});
        drain();

        // Early last
        send_word(32'd5, 1'b0, 1'b0);
        send_word(32'd6, 1'b1, 1'b0);
        chk("t3_err", err_frame, 1);
        chk("t3_count", set_count, 0);
        send_frame(32'd7, 1'b0);
        chk("t3_xyzh", {x, y, z, h}, {32'd7, 32'd8, 32'd9, 32'd10});
        drain();

        // Missing last
        for (int i = 0; i < 4; i++) send_word(32'd1 + 32'(i), 1'b0, 1'b0);
        chk("t4_err", err_frame, 1);
        chk("t4_no_out", out_valid, 0);
        send_frame(32'd20, 1'b0);
        chk("t4_x", x, 32'd20);
        drain();

        // Asynchronous reset mid-frame with a buffered set
        send_frame(32'd30, 1'b0);
        send_word(32'd34, 1'b0, 1'b0);
        send_word(32'd35, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("t5_ready_drop", in_ready, 0);
        chk("t5_valid_drop", out_valid, 0);
        chk("t5_xyzh_zero", {x, y, z, h}, '0);
        chk("t5_count_zero", set_count, 0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        send_frame(32'd11, 1'b0);
        chk("t5_x", {x, y}, {32'd11, 32'd12});
        drain();

        // Simultaneous push and pop
        send_frame(32'd40, 1'b0);
        for (int i = 0; i < 3; i++) send_word(32'd44 + 32'(i), 1'b0, 1'b0);
        send_word(32'd47, 1'b1, 1'b1);
        chk("t6_count", set_count, 1);
        chk("t6_head", {x, h}, {32'd44, 32'd47});
        drain();

        // Randomized traffic with occasional malformed frames
        for (int i = 0; i < 3000; i++) begin
            bit lst;
            lst = (m_stage.size() == 3);
            if ($urandom_range(0, 9) == 0) lst = !lst;
            cycle($urandom_range(0, 3) != 0, $urandom, lst, $urandom_range(0, 2) != 0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
